screen_sequencer: RTL and testbench
===================================

# screen_sequencer

Top-level screen controller for the 96x64 RGB565 OLED user interface. It converts the OLED driver's linear `pixel_index` into `x`/`y` coordinates, owns the home/menu/game/control navigation state machine and the blink timebase, and selects which combinational screen renderer drives `oled_data`. It sits between the OLED driver and the per-screen renderers, which are pure functions of `x`/`y`.

## Interface
- `BLINK_FRAMES`, default 15: frames per blink half-period; legal range 1..255.
- `TIMEOUT_FRAMES`, default 600: idle frames before returning to HOME; legal range 1..4095.

- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `frame_begin` in 1: one-cycle pulse from the OLED driver at the start of each frame.
- `pixel_index` in 13: linear pixel index from the OLED driver, row-major.
- `btn_up`, `btn_down`, `btn_sel`, `btn_back` in 1 each: raw, debounced, asynchronous button levels.
- `home_px`, `menu_px`, `game_px`, `ctrl_px` in 16 each: renderer outputs, combinational in `x`/`y`.
- `x` out 7, `y` out 6: registered pixel coordinates.
- `oled_data` out 16: registered pixel colour.
- `screen` out 2: committed screen code.
- `cursor` out 1: menu cursor (0 = game, 1 = control).
- `blink` out 1: blink phase for renderers.

## Operation
- Coordinates: `x = pixel_index % 96`, `y = pixel_index / 96`. If `pixel_index >= 6144`, force `x = 0`, `y = 0`, and set `oled_data` to BLACK for that pixel.
- Mux: `screen` selects `home_px`, `menu_px`, `game_px` or `ctrl_px` into `oled_data`.
- Buttons: each button is synchronised through 2 flops, then rising-edge detected into a 1-cycle pulse. A held button produces exactly one pulse.
- Same-cycle priority: back > sel > up > down. Lower-priority pulses in that cycle are dropped.
- FSM states: HOME = 0, MENU = 1, GAME = 2, CTRL = 3.
  - HOME: sel -> MENU. All other buttons are ignored.
  - MENU: up sets `cursor = 0`; down sets `cursor = 1`. Cursor does not wrap. sel -> GAME if `cursor = 0`, else CTRL. back -> HOME.
  - GAME and CTRL: back -> MENU. All other buttons are ignored.
- Tear-free commit:
  - A transition writes `next_screen` and sets `pending`.
  - `screen` updates only on `frame_begin`; `pending` clears at the same time.
  - While `pending = 1`, further sel/back pulses are ignored. Up/down remain live in MENU.
  - A transition and a `frame_begin` in the same cycle commit at the next `frame_begin`, not the current one.
- Cursor: set to 0 on every commit into MENU from HOME. Preserved on back from GAME or CTRL.
- Blink:
  - An 8-bit frame counter increments on `frame_begin`.
  - At `BLINK_FRAMES - 1` the counter resets to 0 and `blink` toggles.
  - On every screen commit, the counter resets to 0 and `blink` is set to 1.

## Timing
- Reset values: `x = 0`, `y = 0`, `oled_data = 16'h0000`, `screen = HOME`, `cursor = 0`, `blink = 1`, `pending = 0`, all counters 0.
- Latency: `pixel_index` at cycle n gives `x`/`y` at n+1; the corresponding `oled_data` appears at n+2. The OLED driver must account for the 2-cycle pipeline.
- Button latency: a level change sampled at cycle n produces the internal pulse at n+3 (2 sync flops plus edge register). `cursor` changes at n+4.
- The screen change becomes visible on the first `frame_begin` after the `pending` set. `oled_data` reflects the new screen 1 cycle after the commit.
- Asserting `rst_n` low mid-frame clears everything immediately. After deassertion, the sync flops must refill before any button pulse can occur.

## Configuration
- `SCREEN_SEQ_TIMEOUT_EN` defined:
  - A 12-bit idle counter increments on `frame_begin` while `screen` is MENU or CTRL.
  - Any button pulse or screen commit clears the counter.
  - On reaching `TIMEOUT_FRAMES`, the block requests HOME through the normal pending/commit path.
  - GAME never times out.
- `SCREEN_SEQ_TIMEOUT_EN` undefined: no idle counter, no timeout.

## Structure
- Package `screen_pkg` holds:
  - screen codes HOME, MENU, GAME, CTRL as a 2-bit enum typedef;
  - `OLED_W = 96`, `OLED_H = 64`, `OLED_PIXELS = 6144`;
  - RGB565 colour constants (GREEN, RED, BLACK, WHITE, ...).
- Sub-module `btn_sync_edge`: 2-flop synchroniser plus rising-edge detector, with async active-low reset. Instantiated 4 times.

## Test plan
- Reset, then `pixel_index = 97` -> cycle+1: `x = 1`, `y = 1`; cycle+2: `oled_data = home_px`. `pixel_index = 6200` -> `oled_data = 16'h0000`.
- HOME, pulse `btn_sel` -> `screen` stays 0 until the next `frame_begin`, then becomes 1 with `cursor = 0` and `blink = 1`.
- MENU, down then sel, then `frame_begin` -> `screen = 3`. Then back, then `frame_begin` -> `screen = 1` with `cursor = 1` preserved.
- `btn_back` and `btn_sel` rise in the same cycle in MENU -> next `screen = 0`. Hold `btn_down` for 100 cycles -> exactly one cursor move.
- `BLINK_FRAMES = 3`, 9 `frame_begin` pulses on HOME -> `blink` sequence 1, 0, 1, 0 with toggles after frames 3, 6 and 9.
- With `SCREEN_SEQ_TIMEOUT_EN` and `TIMEOUT_FRAMES = 4`: in MENU, 4 idle frames -> pending HOME, committed at frame 5. The same sequence in GAME -> no change.

Source files
------------

// File: rtl/screen_pkg.sv
// rtl/screen_pkg.sv - screen codes, panel geometry and RGB565 colours
package screen_pkg;

  typedef enum logic [1:0] {
    HOME = 2'd0,
    MENU = 2'd1,
    GAME = 2'd2,
    CTRL = 2'd3
  } screen_t;

  localparam int OLED_W      = 96;
  localparam int OLED_H      = 64;
  localparam int OLED_PIXELS = OLED_W * OLED_H;

  localparam logic [15:0] BLACK  = 16'h0000;
  localparam logic [15:0] WHITE  = 16'hFFFF;
  localparam logic [15:0] RED    = 16'hF800;
  localparam logic [15:0] GREEN  = 16'h07E0;
  localparam logic [15:0] BLUE   = 16'h001F;
  localparam logic [15:0] YELLOW = 16'hFFE0;

endpackage

// File: rtl/btn_sync_edge.sv
// rtl/btn_sync_edge.sv - two-flop synchroniser and registered rising-edge pulse
module btn_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic pulse
);

  logic sync1;
  logic sync2;
  logic prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
      pulse <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      prev  <= sync2;
      pulse <= sync2 & ~prev;
    end
  end

endmodule

// File: rtl/screen_sequencer.sv
// rtl/screen_sequencer.sv - pixel coordinates, screen FSM, blink timebase and renderer mux
// Optional idle timeout back to HOME: define SCREEN_SEQ_TIMEOUT_EN.
module screen_sequencer
  import screen_pkg::*;
#(
  parameter int BLINK_FRAMES   = 15,
  parameter int TIMEOUT_FRAMES = 600
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_begin,
  input  logic [12:0] pixel_index,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_sel,
  input  logic        btn_back,
  input  logic [15:0] home_px,
  input  logic [15:0] menu_px,
  input  logic [15:0] game_px,
  input  logic [15:0] ctrl_px,
  output logic [6:0]  x,
  output logic [5:0]  y,
  output logic [15:0] oled_data,
  output logic [1:0]  screen,
  output logic        cursor,
  output logic        blink
);

  localparam logic [7:0]  BLINK_LAST = 8'(BLINK_FRAMES - 1);
  localparam logic [11:0] IDLE_LIMIT = 12'(TIMEOUT_FRAMES);

  logic    up_p, down_p, sel_p, back_p;
  screen_t screen_q;
  screen_t next_screen;
  logic    pending;
  logic    commit;
  logic    in_range;
  logic    idle_screen;
  logic    timeout_req;
  logic [7:0]  blink_cnt;
  logic [11:0] idle_cnt;
  logic [15:0] pix_sel;

  btn_sync_edge u_up   (.clk(clk), .rst_n(rst_n), .btn(btn_up),   .pulse(up_p));
  btn_sync_edge u_down (.clk(clk), .rst_n(rst_n), .btn(btn_down), .pulse(down_p));
  btn_sync_edge u_sel  (.clk(clk), .rst_n(rst_n), .btn(btn_sel),  .pulse(sel_p));
  btn_sync_edge u_back (.clk(clk), .rst_n(rst_n), .btn(btn_back), .pulse(back_p));

  assign screen      = screen_q;
  assign commit      = frame_begin & pending;
  assign idle_screen = (screen_q == MENU) || (screen_q == CTRL);

  // Stage 1 latches coordinates; stage 2 samples the renderer that saw them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x         <= '0;
      y         <= '0;
      in_range  <= 1'b0;
      oled_data <= BLACK;
    end else begin
      if (pixel_index < 13'(OLED_PIXELS)) begin
        x        <= 7'(pixel_index % 13'(OLED_W));
        y        <= 6'(pixel_index / 13'(OLED_W));
        in_range <= 1'b1;
      end else begin
        x        <= '0;
        y        <= '0;
        in_range <= 1'b0;
      end
      oled_data <= in_range ? pix_sel : BLACK;
    end
  end

  always_comb begin
    pix_sel = home_px;
    case (screen_q)
      HOME:    pix_sel = home_px;
      MENU:    pix_sel = menu_px;
      GAME:    pix_sel = game_px;
      CTRL:    pix_sel = ctrl_px;
      default: pix_sel = home_px;
    endcase
  end

`ifdef SCREEN_SEQ_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= '0;
    end else if (up_p || down_p || sel_p || back_p || commit) begin
      idle_cnt <= '0;
    end else if (frame_begin && idle_screen && (idle_cnt != 12'hFFF)) begin
      idle_cnt <= idle_cnt + 12'd1;
    end
  end
`else
  assign idle_cnt = '0;
`endif

  assign timeout_req = !pending && idle_screen && (idle_cnt >= IDLE_LIMIT);

  // next_screen is the navigation state; screen_q only follows it on frame_begin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      next_screen <= HOME;
      screen_q    <= HOME;
      pending     <= 1'b0;
      cursor      <= 1'b0;
      blink       <= 1'b1;
      blink_cnt   <= '0;
    end else begin
      if (commit) begin
        screen_q  <= next_screen;
        pending   <= 1'b0;
        blink_cnt <= '0;
        blink     <= 1'b1;
      end else if (frame_begin) begin
        if (blink_cnt == BLINK_LAST) begin
          blink_cnt <= '0;
          blink     <= ~blink;
        end else begin
          blink_cnt <= blink_cnt + 8'd1;
        end
      end

      if (back_p) begin
        if (!pending) begin
          case (next_screen)
            MENU:       begin next_screen <= HOME; pending <= 1'b1; end
            GAME, CTRL: begin next_screen <= MENU; pending <= 1'b1; end
            default: ;
          endcase
        end
      end else if (sel_p) begin
        if (!pending) begin
          case (next_screen)
            HOME:    begin next_screen <= MENU; pending <= 1'b1; end
            MENU:    begin next_screen <= cursor ? CTRL : GAME; pending <= 1'b1; end
            default: ;
          endcase
        end
      end else if (up_p) begin
        if (next_screen == MENU) cursor <= 1'b0;
      end else if (down_p) begin
        if (next_screen == MENU) cursor <= 1'b1;
      end else if (timeout_req) begin
        next_screen <= HOME;
        pending     <= 1'b1;
      end

      if (commit && (screen_q == HOME) && (next_screen == MENU)) cursor <= 1'b0;
    end
  end

endmodule

// File: tb/tb_screen_sequencer.sv
// tb/tb_screen_sequencer.sv - randomized bench for screen_sequencer against a navigation model
module tb_screen_sequencer;

  localparam int BLINK = 3;
  localparam int TMO   = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_begin = 1'b0;
  logic [12:0] pixel_index = '0;
  logic        btn_up = 1'b0, btn_down = 1'b0, btn_sel = 1'b0, btn_back = 1'b0;
  logic [15:0] home_px, menu_px, game_px, ctrl_px;
  logic [6:0]  x;
  logic [5:0]  y;
  logic [15:0] oled_data;
  logic [1:0]  screen;
  logic        cursor;
  logic        blink;

  always #5 clk = ~clk;

  assign home_px = {3'd1, x, y};
  assign menu_px = {3'd2, x, y};
  assign game_px = {3'd3, x, y};
  assign ctrl_px = {3'd4, x, y};

  screen_sequencer #(.BLINK_FRAMES(BLINK), .TIMEOUT_FRAMES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .frame_begin(frame_begin), .pixel_index(pixel_index),
    .btn_up(btn_up), .btn_down(btn_down), .btn_sel(btn_sel), .btn_back(btn_back),
    .home_px(home_px), .menu_px(menu_px), .game_px(game_px), .ctrl_px(ctrl_px),
    .x(x), .y(y), .oled_data(oled_data), .screen(screen), .cursor(cursor), .blink(blink)
  );

  int checks = 0;
  int failures = 0;

  // Navigation model: committed screen, target screen, pending flag, cursor,
  // frames since last commit (blink phase) and idle frames.
  int m_scr = 0, m_next = 0, m_pend = 0, m_cur = 0, m_frames = 0, m_idle = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic int exp_blink();
    return ((m_frames / BLINK) % 2 == 0) ? 1 : 0;
  endfunction

  function automatic logic [15:0] exp_pixel(input int idx, input int scr);
    logic [6:0] ex;
    logic [5:0] ey;
    if (idx >= 6144) return 16'h0000;
    ex = 7'(idx % 96);
    ey = 6'(idx / 96);
    return {3'(scr + 1), ex, ey};
  endfunction

  task automatic check_state(input string tag);
    check({tag, "_screen"}, screen, m_scr);
    check({tag, "_cursor"}, cursor, m_cur);
    check({tag, "_blink"}, blink, exp_blink());
  endtask

  task automatic go(input int target);
    m_next = target;
    m_pend = 1;
  endtask

  // mask = {back, sel, up, down}
  task automatic model_press(input logic [3:0] mask);
    if (mask[3]) begin
      if (m_pend == 0) begin
        if (m_next == 1) go(0);
        else if (m_next >= 2) go(1);
      end
    end else if (mask[2]) begin
      if (m_pend == 0) begin
        if (m_next == 0) go(1);
        else if (m_next == 1) go(m_cur ? 3 : 2);
      end
    end else if (mask[1]) begin
      if (m_next == 1) m_cur = 0;
    end else if (mask[0]) begin
      if (m_next == 1) m_cur = 1;
    end
    if (mask != 4'b0) m_idle = 0;
  endtask

  task automatic model_frame();
    if (m_pend != 0) begin
      if (m_scr == 0 && m_next == 1) m_cur = 0;
      m_scr    = m_next;
      m_pend   = 0;
      m_frames = 0;
      m_idle   = 0;
    end else begin
      m_frames++;
      if (m_scr == 1 || m_scr == 3) m_idle++;
    end
`ifdef SCREEN_SEQ_TIMEOUT_EN
    if (m_pend == 0 && (m_scr == 1 || m_scr == 3) && m_idle >= TMO) go(0);
`endif
  endtask

  task automatic drive_btns(input logic [3:0] mask);
    btn_back = mask[3];
    btn_sel  = mask[2];
    btn_up   = mask[1];
    btn_down = mask[0];
  endtask

  task automatic press(input logic [3:0] mask, input string tag);
    @(posedge clk); #1;
    drive_btns(mask);
    repeat (6) @(posedge clk);
    #1 drive_btns(4'b0);
    repeat (6) @(posedge clk);
    model_press(mask);
    @(negedge clk);
    check_state(tag);
  endtask

  task automatic frame(input string tag);
    @(posedge clk); #1 frame_begin = 1'b1;
    @(posedge clk); #1 frame_begin = 1'b0;
    repeat (2) @(posedge clk);
    model_frame();
    @(negedge clk);
    check_state(tag);
  endtask

  task automatic pix_stream(input int n);
    int idx[$];
    idx = '{97, 6200, 0, 95, 96, 6143, 6144, 8191};
    while (idx.size() < n) idx.push_back(int'($urandom_range(0, 8191)));
    for (int i = 0; i < idx.size() + 2; i++) begin
      @(posedge clk); #1;
      if (i < idx.size()) pixel_index = 13'(idx[i]);
      @(negedge clk);
      if (i >= 1 && i <= idx.size()) begin
        check("pix_x", x, (idx[i-1] >= 6144) ? 0 : idx[i-1] % 96);
        check("pix_y", y, (idx[i-1] >= 6144) ? 0 : idx[i-1] / 96);
      end
      if (i >= 2) check("pix_data", oled_data, exp_pixel(idx[i-2], m_scr));
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_x", x, 0);
    check("rst_y", y, 0);
    check("rst_oled", oled_data, 16'h0000);
    check_state("rst");
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);

    pix_stream(24);

    for (int f = 0; f < 9; f++) frame("blink_home");

    press(4'b0100, "home_sel");
    check("home_sel_held", screen, 0);
    frame("to_menu");
    check("menu_commit", screen, 1);

    press(4'b0001, "menu_down");
    press(4'b0100, "menu_sel_ctrl");
    frame("to_ctrl");
    check("ctrl_commit", screen, 3);
    press(4'b1000, "ctrl_back");
    frame("back_menu");
    check("cursor_kept", cursor, 1);

    // cursor moves exactly four edges after the level is driven
    @(posedge clk); #1 btn_up = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk) check("up_lat3", cursor, 1);
    @(posedge clk);
    @(negedge clk) check("up_lat4", cursor, 0);
    #1 btn_up = 1'b0;
    repeat (6) @(posedge clk);
    model_press(4'b0010);

    @(posedge clk); #1 btn_down = 1'b1;
    repeat (100) @(posedge clk);
    #1 btn_down = 1'b0;
    repeat (6) @(posedge clk);
    model_press(4'b0001);
    @(negedge clk);
    check_state("hold_down");

    press(4'b1100, "back_and_sel");
    frame("back_wins");
    check("back_wins_home", screen, 0);

    // sel pulse lands in the same cycle as frame_begin: commit waits a frame
    @(posedge clk); #1 btn_sel = 1'b1;
    repeat (3) @(posedge clk);
    #1 frame_begin = 1'b1;
    @(posedge clk); #1 frame_begin = 1'b0;
    repeat (3) @(posedge clk);
    #1 btn_sel = 1'b0;
    repeat (6) @(posedge clk);
    model_frame();
    model_press(4'b0100);
    @(negedge clk);
    check_state("sel_on_frame");
    check("sel_on_frame_held", screen, 0);
    frame("sel_on_frame_commit");

    for (int f = 0; f < TMO; f++) frame("menu_idle");
    check("idle_f4", screen, 1);
    frame("idle_f5");
`ifdef SCREEN_SEQ_TIMEOUT_EN
    check("timeout_home", screen, 0);
`else
    check("no_timeout", screen, 1);
`endif

    if (m_scr == 0) begin
      press(4'b0100, "to_menu2");
      frame("to_menu2_commit");
    end
    press(4'b0100, "to_game");
    frame("game_commit");
    for (int f = 0; f < TMO + 2; f++) frame("game_idle");
    check("game_no_timeout", screen, 2);

    pix_stream(12);

    for (int e = 0; e < 200; e++) begin
      case ($urandom_range(0, 9))
        0, 6, 8: frame("rnd_frame");
        2:       press(4'b0010, "rnd_up");
        3:       press(4'b0001, "rnd_down");
        4, 9:    press(4'b0100, "rnd_sel");
        5:       press(4'b1000, "rnd_back");
        default: press(4'($urandom_range(1, 15)), "rnd_combo");
      endcase
    end

    pix_stream(10);

    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    check("mid_rst_screen", screen, 0);
    check("mid_rst_cursor", cursor, 0);
    check("mid_rst_blink", blink, 1);
    check("mid_rst_oled", oled_data, 16'h0000);
    check("mid_rst_x", x, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
